// File: rtl/svpwm_gate_sequencer_pkg.sv
// rtl/svpwm_gate_sequencer_pkg.sv - shared constants, sector table and threshold helpers
package svpwm_gate_sequencer_pkg;

  localparam int unsigned PERIOD_DEFAULT = 8000;
  localparam int unsigned DEAD_DEFAULT   = 50;
  localparam int unsigned CNT_W_DEFAULT  = 14;
  localparam int unsigned CALC_W         = 16;
  localparam logic [2:0]  SECTOR_INVALID = 3'd0;

  typedef enum logic [1:0] {THR_LO, THR_M1, THR_M2, THR_HI} thr_sel_e;

  typedef struct packed {
    thr_sel_e a;
    thr_sel_e b;
    thr_sel_e c;
  } phase_sel_t;

  // 30-degree sub-sectors 1..12 fold onto the six 60-degree sectors.
  function automatic logic [2:0] sector_of(input logic [3:0] number_sector);
    logic [4:0] s;
    s = (5'(number_sector) + 5'd1) >> 1;
    if (number_sector == 4'd0 || number_sector > 4'd12) return SECTOR_INVALID;
    return s[2:0];
  endfunction

  function automatic phase_sel_t sector_sel(input logic [2:0] s);
    phase_sel_t sel;
    case (s)
      3'd1:    sel = '{a: THR_LO, b: THR_M1, c: THR_HI};
      3'd2:    sel = '{a: THR_M2, b: THR_LO, c: THR_HI};
      3'd3:    sel = '{a: THR_HI, b: THR_LO, c: THR_M1};
      3'd4:    sel = '{a: THR_HI, b: THR_M2, c: THR_LO};
      3'd5:    sel = '{a: THR_M1, b: THR_HI, c: THR_LO};
      3'd6:    sel = '{a: THR_LO, b: THR_HI, c: THR_M2};
      default: sel = '{a: THR_LO, b: THR_LO, c: THR_LO};
    endcase
    return sel;
  endfunction

  function automatic logic [CALC_W-1:0] pick(input thr_sel_e sel,
                                             input logic [CALC_W-1:0] lo,
                                             input logic [CALC_W-1:0] m1,
                                             input logic [CALC_W-1:0] m2,
                                             input logic [CALC_W-1:0] hi);
    logic [CALC_W-1:0] v;
    case (sel)
      THR_LO:  v = lo;
      THR_M1:  v = m1;
      THR_M2:  v = m2;
      default: v = hi;
    endcase
    return v;
  endfunction

  function automatic logic [CALC_W-1:0] sat(input logic [CALC_W-1:0] v,
                                            input logic [CALC_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/svpwm_gate_sequencer_if.sv
// rtl/svpwm_gate_sequencer_if.sv - vector-time inputs and gate/carrier outputs of the sequencer
interface svpwm_gate_sequencer_if
  import svpwm_gate_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);
  logic             enable;
  logic [3:0]       number_sector;
  logic [CNT_W-1:0] T1;
  logic [CNT_W-1:0] T2;
  logic [CNT_W-1:0] T0;
  logic             synchr_clk;
  logic [CNT_W-1:0] carrier;
  logic             a_hi, a_lo, b_hi, b_lo, c_hi, c_lo;

  modport master (
    output enable, number_sector, T1, T2, T0,
    input  synchr_clk, carrier, a_hi, a_lo, b_hi, b_lo, c_hi, c_lo
  );

  modport slave (
    input  enable, number_sector, T1, T2, T0,
    output synchr_clk, carrier, a_hi, a_lo, b_hi, b_lo, c_hi, c_lo
  );
endinterface

// File: rtl/svpwm_gate_sequencer_dead_time_inserter.sv
// rtl/svpwm_gate_sequencer_dead_time_inserter.sv - complementary leg drive with rising-edge dead-time
module svpwm_gate_sequencer_dead_time_inserter
  import svpwm_gate_sequencer_pkg::*;
#(
  parameter int unsigned DEAD = DEAD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic raw_i,
  output logic hi_o,
  output logic lo_o
);
  localparam int unsigned CW     = (DEAD < 1) ? 1 : $clog2(DEAD + 1);
  localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hi_q, lo_q;
  logic          settled;

  // cnt counts samples equal to the previous one; a leg turns on only once raw
  // has held for DEAD+1 samples, so pulses of DEAD clocks or less vanish.
  always_comb begin
    if (raw_i != prev_q)      cnt_d = '0;
    else if (cnt_q == DEAD_C) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 1'b1;
    settled = (cnt_d == DEAD_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= 1'b0;
      lo_q   <= 1'b0;
    end else begin
      prev_q <= raw_i;
      if (!enable_i) begin
        cnt_q <= '0;
        hi_q  <= 1'b0;
        lo_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        hi_q  <= raw_i & settled;
        lo_q  <= ~raw_i & settled;
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: rtl/svpwm_gate_sequencer.sv
// rtl/svpwm_gate_sequencer.sv - triangle carrier, shadowed 7-segment thresholds and gated leg drives
module svpwm_gate_sequencer
  import svpwm_gate_sequencer_pkg::*;
#(
  parameter int unsigned PERIOD = PERIOD_DEFAULT,
  parameter int unsigned DEAD   = DEAD_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input logic                   clk,
  input logic                   reset,
  svpwm_gate_sequencer_if.slave vt_if
);
  // Thresholds carry one extra bit so the invalid value PERIOD+1 is representable.
  localparam int unsigned       TW          = CNT_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_TOP_M1  = CNT_W'(PERIOD - 1);
  localparam logic [CALC_W-1:0] PERIOD_CALC = CALC_W'(PERIOD);
  localparam logic [TW-1:0]     THR_PERIOD  = TW'(PERIOD);
  localparam logic [TW-1:0]     THR_INVALID = TW'(PERIOD + 1);

  logic [CNT_W-1:0]     carrier_q, carrier_d;
  logic                 up_q, up_d;
  logic                 synchr_q;
  logic [2:0][TW-1:0]   thr_q, thr_d;
  logic [2:0]           raw_q, raw_d;
  logic                 load;
  logic [CALC_W-1:0]    lo, m1, m2, hi;
  logic [2:0]           sector;
  phase_sel_t           sel;
  logic [2:0]           gate_hi, gate_lo;

  always_comb begin
    up_d = up_q;
    if (up_q) begin
      carrier_d = carrier_q + 1'b1;
      if (carrier_q == CNT_TOP_M1) up_d = 1'b0;
    end else begin
      carrier_d = carrier_q - 1'b1;
      if (carrier_q == CNT_ONE) up_d = 1'b1;
    end
  end

  // Shadow update one clock before the valley so the new pattern starts at carrier 0.
  assign load = !up_q && (carrier_q == CNT_ONE);

  always_comb begin
    lo = CALC_W'(vt_if.T0) >> 1;
    m1 = lo + CALC_W'(vt_if.T1);
    m2 = lo + CALC_W'(vt_if.T2);
    hi = m1 + CALC_W'(vt_if.T2);
  end

  assign sector = sector_of(vt_if.number_sector);
  assign sel    = sector_sel(sector);

  always_comb begin
    thr_d = thr_q;
    if (load) begin
      if (sector == SECTOR_INVALID) begin
        thr_d = {3{THR_INVALID}};
      end else begin
        thr_d[0] = TW'(sat(pick(sel.a, lo, m1, m2, hi), PERIOD_CALC));
        thr_d[1] = TW'(sat(pick(sel.b, lo, m1, m2, hi), PERIOD_CALC));
        thr_d[2] = TW'(sat(pick(sel.c, lo, m1, m2, hi), PERIOD_CALC));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      raw_d[i] = ({1'b0, carrier_q} >= thr_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carrier_q <= '0;
      up_q      <= 1'b1;
      synchr_q  <= 1'b0;
      thr_q     <= {3{THR_PERIOD}};
      raw_q     <= '0;
    end else begin
      carrier_q <= carrier_d;
      up_q      <= up_d;
      synchr_q  <= up_d;
      thr_q     <= thr_d;
      raw_q     <= raw_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_leg
    svpwm_gate_sequencer_dead_time_inserter #(
      .DEAD (DEAD)
    ) u_dt (
      .clk      (clk),
      .reset    (reset),
      .enable_i (vt_if.enable),
      .raw_i    (raw_q[i]),
      .hi_o     (gate_hi[i]),
      .lo_o     (gate_lo[i])
    );
  end

  assign vt_if.carrier    = carrier_q;
  assign vt_if.synchr_clk = synchr_q;
  assign vt_if.a_hi       = gate_hi[0];
  assign vt_if.a_lo       = gate_lo[0];
  assign vt_if.b_hi       = gate_hi[1];
  assign vt_if.b_lo       = gate_lo[1];
  assign vt_if.c_hi       = gate_hi[2];
  assign vt_if.c_lo       = gate_lo[2];
endmodule

// File: tb/tb_svpwm_gate_sequencer.sv
// tb/tb_svpwm_gate_sequencer.sv - scoreboard bench with a cycle-indexed reference model
module tb_svpwm_gate_sequencer;
  localparam int P     = 1000;
  localparam int DEAD  = 50;
  localparam int CNT_W = 14;
  localparam int TWO_P = 2 * P;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  svpwm_gate_sequencer_if #(.CNT_W(CNT_W)) vif();

  svpwm_gate_sequencer #(
    .PERIOD (P),
    .DEAD   (DEAD),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vt_if (vif)
  );

  typedef struct {
    int       carrier;
    bit       synchr;
    bit [5:0] gates;
  } exp_t;

  typedef struct {
    bit [2:0] raw;
    bit       en;
  } samp_t;

  exp_t     exp_q[$];
  samp_t    hist[$];
  int       n;
  int       thr_act[3];
  bit [2:0] raw_m;
  int       vectors     = 0;
  int       miscompares = 0;

  function automatic int tri_at(int idx);
    int p;
    p = idx % TWO_P;
    return (p <= P) ? p : TWO_P - p;
  endfunction

  function automatic int clampp(int v);
    return (v > P) ? P : v;
  endfunction

  task automatic load_thresholds();
    int lo, m1, m2, hi, ns, s;
    ns = int'(vif.number_sector);
    lo = int'(vif.T0) / 2;
    m1 = clampp(lo + int'(vif.T1));
    m2 = clampp(lo + int'(vif.T2));
    hi = clampp(lo + int'(vif.T1) + int'(vif.T2));
    lo = clampp(lo);
    if (ns < 1 || ns > 12) begin
      thr_act = '{P + 1, P + 1, P + 1};
    end else begin
      s = (ns + 1) / 2;
      case (s)
        1:       thr_act = '{lo, m1, hi};
        2:       thr_act = '{m2, lo, hi};
        3:       thr_act = '{hi, lo, m1};
        4:       thr_act = '{hi, m2, lo};
        5:       thr_act = '{m1, hi, lo};
        default: thr_act = '{lo, hi, m2};
      endcase
    end
  endtask

  // A leg is on when its raw level held over the last DEAD+1 samples and
  // enable was high for the last DEAD of them.
  function automatic bit [5:0] gates_expected();
    bit [5:0] g;
    bit       en_ok, all1, all0;
    int       sz;
    g  = '0;
    sz = hist.size();
    if (sz >= DEAD + 1) begin
      en_ok = 1'b1;
      for (int k = sz - DEAD; k < sz; k++) if (!hist[k].en) en_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
        all1 = 1'b1;
        all0 = 1'b1;
        for (int k = sz - DEAD - 1; k < sz; k++) begin
          if (hist[k].raw[i]) all0 = 1'b0;
          else                all1 = 1'b0;
        end
        g[5 - 2 * i] = en_ok && all1;
        g[4 - 2 * i] = en_ok && all0;
      end
    end
    return g;
  endfunction

  task automatic model_step();
    exp_t     e;
    samp_t    s;
    bit [2:0] raw_new;
    if (reset) begin
      n       = 0;
      thr_act = '{P, P, P};
      raw_m   = '0;
      hist.delete();
      s.raw = '0;
      s.en  = 1'b0;
      hist.push_back(s);
    end else begin
      s.raw = raw_m;
      s.en  = vif.enable;
      hist.push_back(s);
      if (hist.size() > DEAD + 1) void'(hist.pop_front());
      for (int i = 0; i < 3; i++) raw_new[i] = (tri_at(n) >= thr_act[i]);
      if ((n % TWO_P) == TWO_P - 1) load_thresholds();
      raw_m = raw_new;
      n++;
    end
    e.carrier = tri_at(n);
    e.synchr  = (n == 0) ? 1'b0 : ((n % TWO_P) < P);
    e.gates   = gates_expected();
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(int cycles);
    repeat (cycles) tick();
  endtask

  task automatic run_to(int phase);
    int guard;
    guard = 0;
    while ((n % TWO_P) != phase && guard < TWO_P + 2) begin
      tick();
      guard++;
    end
  endtask

  task automatic set_vt(int ns, int t1, int t2, int t0);
    vif.number_sector = 4'(ns);
    vif.T1 = CNT_W'(t1);
    vif.T2 = CNT_W'(t2);
    vif.T0 = CNT_W'(t0);
  endtask

  function automatic int rand_t();
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom_range(0, 120));
      1:       v = int'($urandom_range(0, P));
      2:       v = int'($urandom_range(0, P / 2));
      default: v = int'($urandom_range(0, 16383));
    endcase
    return v;
  endfunction

  task automatic rand_vt();
    int ns;
    ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 12));
    set_vt(ns, rand_t(), rand_t(), rand_t());
  endtask

  always @(negedge clk) begin
    exp_t     e;
    bit [5:0] g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {vif.a_hi, vif.a_lo, vif.b_hi, vif.b_lo, vif.c_hi, vif.c_lo};
      vectors++;
      if (int'(vif.carrier) !== e.carrier) begin
        miscompares++;
        $display("FAIL carrier t=%0t: got %0d expected %0d", $time, vif.carrier, e.carrier);
      end
      vectors++;
      if (vif.synchr_clk !== e.synchr) begin
        miscompares++;
        $display("FAIL synchr_clk t=%0t: got %b expected %b", $time, vif.synchr_clk, e.synchr);
      end
      vectors++;
      if (g !== e.gates) begin
        miscompares++;
        $display("FAIL gates(ah,al,bh,bl,ch,cl) t=%0t: got %b expected %b", $time, g, e.gates);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    vif.enable = 1'b0;
    set_vt(1, 250, 125, 625);
    tick();
    tick();
    reset = 1'b0;

    // Gates-off period: carrier and synchr_clk only, shadow picks up sector 1.
    run(TWO_P);

    // Sector 1 pattern, while sector 7 is queued for the next valley.
    vif.enable = 1'b1;
    set_vt(7, 250, 125, 625);
    run(TWO_P);
    run(TWO_P);

    // Mid-period T1 change must wait for the following valley.
    set_vt(1, 250, 125, 625);
    run(TWO_P);
    run_to(750);
    vif.T1 = CNT_W'(375);
    run_to(0);
    run(P);

    // Enable drop on the down-slope, then full re-qualification.
    run_to(1250);
    vif.enable = 1'b0;
    run(300);
    vif.enable = 1'b1;
    run_to(0);

    // Saturated dwell, then invalid sector.
    set_vt(1, P, P, 0);
    run(TWO_P);
    set_vt(0, 250, 125, 625);
    run(TWO_P);
    run(TWO_P);

    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vif.enable = 1'b0;
        run(TWO_P);
        vif.enable = 1'b1;
      end
      for (int c = 0; c < TWO_P; c++) begin
        if (c == 0 || $urandom_range(0, 199) == 0) rand_vt();
        if ($urandom_range(0, 699) == 0) vif.enable = ~vif.enable;
        tick();
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
